// File: rtl/uart_div_pkg.sv
// Shared definitions for the UART-to-divider frame sequencer.
// State encoding, frame geometry and byte-lane helpers.
package uart_div_pkg;

    localparam int FRAME_BYTES  = 4;
    localparam int ACK_WAIT_CYC = 4;

    localparam logic [1:0] POS_A_LO = 2'd0;
    localparam logic [1:0] POS_A_HI = 2'd1;
    localparam logic [1:0] POS_B_LO = 2'd2;
    localparam logic [1:0] POS_B_HI = 2'd3;

    typedef enum logic [2:0] {
        COLLECT,
        CHECK,
        DIV_WAIT,
        TX_LOAD,
        TX_ACK,
        TX_DRAIN
    } state_t;

    function automatic logic [7:0] frame_byte(
        input logic [31:0] w,
        input logic [1:0]  k
    );
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/byte_tx_seq.sv
// Streams a 4-byte little-endian word to the UART transmitter,
// one byte per busy handshake.
module byte_tx_seq
    import uart_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go_i,
    input  logic [31:0] word_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic        done_o
);

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [1:0] ack_q, ack_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            k_q     <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ack_q   <= ack_d;
        end
    end

    // COLLECT doubles as the idle state of this loop
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ack_d      = ack_q;
        tx_start_o = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (go_i) begin
                    k_d     = '0;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    ack_d      = '0;
                    state_d    = TX_ACK;
                end
            end
            TX_ACK: begin
                if (tx_busy_i) begin
                    state_d = TX_DRAIN;
                end else if (ack_q == 2'(ACK_WAIT_CYC - 1)) begin
                    state_d = TX_DRAIN;
                end else begin
                    ack_d = ack_q + 2'd1;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy_i) begin
                    if (k_q == 2'(FRAME_BYTES - 1)) begin
                        done_o  = 1'b1;
                        k_d     = '0;
                        state_d = COLLECT;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = TX_LOAD;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign tx_data_o = frame_byte(word_i, k_q);

endmodule

// File: rtl/uart_div_sched.sv
// Collects a 4-byte operand frame, runs the shared divider and
// hands the 4-byte result frame to the transmit sequencer.
module uart_div_sched
    import uart_div_pkg::*;
#(
    parameter int                 BIT_MAX     = 16,
    parameter int                 TIMEOUT_CYC = 434000,
    parameter logic [BIT_MAX-1:0] DZ_QUOT     = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               div_start,
    output logic [BIT_MAX-1:0] div_a,
    output logic [BIT_MAX-1:0] div_b,
    input  logic               div_done,
    input  logic [BIT_MAX-1:0] div_q,
    input  logic [BIT_MAX-1:0] div_r,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [23:0]        y_to_led,
    output logic               dz_err,
    output logic               ovr_err,
    output logic               busy
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [BIT_MAX-1:0] a_q, a_d, b_q, b_d;
    logic [BIT_MAX-1:0] q_q, q_d, r_q, r_d;
    logic [BIT_MAX-1:0] led_q, led_d;
    logic               dz_q, dz_d;
    logic               ovr_q, ovr_d;
    logic               start_q, start_d;
    logic               go, tx_done, to_fire;
    logic               st_en;
    logic [1:0]         st_pos;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            to_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            led_q   <= '0;
            dz_q    <= 1'b0;
            ovr_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            led_q   <= led_d;
            dz_q    <= dz_d;
            ovr_q   <= ovr_d;
            start_q <= start_d;
        end
    end

    assign to_fire = (cnt_q != '0) && (to_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        led_d   = led_q;
        dz_d    = dz_q;
        ovr_d   = ovr_q;
        start_d = 1'b0;
        go      = 1'b0;
        st_en   = 1'b0;
        st_pos  = cnt_q;
        unique case (state_q)
            COLLECT: begin
                // an expiring timeout restarts the frame with this byte
                if (to_fire) begin
                    to_d  = '0;
                    cnt_d = '0;
                    if (rx_valid) begin
                        st_en  = 1'b1;
                        st_pos = POS_A_LO;
                        cnt_d  = 2'd1;
                        dz_d   = 1'b0;
                        ovr_d  = 1'b0;
                    end
                end else if (rx_valid) begin
                    st_en = 1'b1;
                    to_d  = '0;
                    if (cnt_q == POS_A_LO) begin
                        dz_d  = 1'b0;
                        ovr_d = 1'b0;
                    end
                    if (cnt_q == 2'(FRAME_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (cnt_q != '0) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            CHECK: begin
                if (b_q == '0) begin
                    q_d     = DZ_QUOT;
                    r_d     = a_q;
                    led_d   = DZ_QUOT;
                    dz_d    = 1'b1;
                    go      = 1'b1;
                    state_d = TX_LOAD;
                end else begin
                    start_d = 1'b1;
                    state_d = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    led_d   = div_q;
                    go      = 1'b1;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (rx_valid && (state_q != COLLECT)) begin
            ovr_d = 1'b1;
        end

        if (st_en) begin
            unique case (st_pos)
                POS_A_LO: a_d[7:0]  = rx_data;
                POS_A_HI: a_d[15:8] = rx_data;
                POS_B_LO: b_d[7:0]  = rx_data;
                POS_B_HI: b_d[15:8] = rx_data;
            endcase
        end
    end

    byte_tx_seq u_tx (
        .clk        (clk),
        .rst        (rst),
        .go_i       (go),
        .word_i     ({r_q, q_q}),
        .tx_busy_i  (tx_busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .done_o     (tx_done)
    );

    assign div_start = start_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign y_to_led  = {{(24 - BIT_MAX){1'b0}}, led_q};
    assign dz_err    = dz_q;
    assign ovr_err   = ovr_q;
    assign busy      = (state_q != COLLECT);

endmodule

// File: tb/tb_uart_div_sched.sv
// Bench for uart_div_sched: divider and transmitter models,
// table-driven and random frames against an arithmetic reference.
module tb_uart_div_sched;

    localparam int TB_TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        div_start;
    logic [15:0] div_a, div_b;
    logic        div_done;
    logic [15:0] div_q, div_r;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [23:0] y_to_led;
    logic        dz_err, ovr_err, busy;

    uart_div_sched #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .y_to_led  (y_to_led),
        .dz_err    (dz_err),
        .ovr_err   (ovr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int div_lat = 16;
    int tx_hold = 0;
    bit stab_chk = 1'b1;

    int n_start = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int unstable = 0;
    logic [15:0] pa = '0;
    logic [15:0] pb = '0;

    logic [7:0] txq[$];
    int txc[$];
    int busy_viol = 0;
    int frame_rx_cyc = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        int          hold;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return {a, 16'hFFFF};
        return {a % b, a / b};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input bit skip_first);
        logic [7:0] by [4];
        by[0] = a[7:0];
        by[1] = a[15:8];
        by[2] = b[7:0];
        by[3] = b[15:8];
        for (int i = (skip_first ? 1 : 0); i < 4; i++) begin
            if (i > 0) tick($urandom_range(0, 2));
            if (i == 3) frame_rx_cyc = cyc;
            send_byte(by[i]);
        end
    endtask

    task automatic finish_frame(input string nm, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic dz, input int n0);
        logic [7:0] eb [4];
        int guard;
        eb[0] = q[7:0];
        eb[1] = q[15:8];
        eb[2] = r[7:0];
        eb[3] = r[15:8];
        guard = 0;
        while (txq.size() < 4 && guard < 4000) begin
            tick(1);
            guard++;
        end
        guard = 0;
        while (busy && guard < 200) begin
            tick(1);
            guard++;
        end
        tick(2);
        check({nm, " tx_count"}, txq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s tx_byte%0d", nm, i),
                  (txq.size() > i) ? {24'h0, txq[i]} : 32'hDEAD, {24'h0, eb[i]});
        end
        check({nm, " y_to_led"}, y_to_led, {16'h0, q});
        check({nm, " dz_err"}, dz_err, dz);
        check({nm, " busy_after"}, busy, 0);
        check({nm, " div_starts"}, n_start - n0, (b != 16'd0) ? 1 : 0);
        if (b != 16'd0) begin
            check({nm, " start_latency"}, start_cyc - frame_rx_cyc, 2);
            check({nm, " div_ab"}, {pa, pb}, {a, b});
            if (txc.size() > 0)
                check({nm, " tx_latency"}, txc[0] - done_cyc, 1);
        end
        check({nm, " tx_start_while_busy"}, busy_viol, 0);
        check({nm, " operand_stable"}, unstable, 0);
        txq.delete();
        txc.delete();
    endtask

    // divider model: answers div_lat cycles after div_start
    initial begin
        int left;
        bit pend;
        bit st, dn;
        int sc;
        logic [15:0] sa, sb;
        left = 0;
        pend = 1'b0;
        div_done = 1'b0;
        div_q = '0;
        div_r = '0;
        forever begin
            @(negedge clk);
            st = div_start;
            sa = div_a;
            sb = div_b;
            dn = div_done;
            sc = cyc;
            if (dn && stab_chk && (sa !== pa || sb !== pb)) unstable++;
            @(posedge clk);
            #1;
            div_done = 1'b0;
            if (st) begin
                pend = 1'b1;
                left = div_lat;
                pa = sa;
                pb = sb;
                n_start++;
                start_cyc = sc;
            end
            if (pend) begin
                left--;
                if (left <= 0) begin
                    div_done = 1'b1;
                    div_q = (pb == 16'd0) ? 16'hFFFF : pa / pb;
                    div_r = (pb == 16'd0) ? pa : pa % pb;
                    done_cyc = cyc;
                    pend = 1'b0;
                end
            end
        end
    end

    // transmitter model: busy for tx_hold cycles per byte, never if 0
    initial begin
        int bleft;
        bit s, bz;
        int sc;
        logic [7:0] d;
        bleft = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            s = tx_start;
            d = tx_data;
            bz = tx_busy;
            sc = cyc;
            if (s) begin
                if (bz) busy_viol++;
                txq.push_back(d);
                txc.push_back(sc);
            end
            @(posedge clk);
            #1;
            if (s && tx_hold > 0) begin
                tx_busy = 1'b1;
                bleft = tx_hold;
            end else if (tx_busy) begin
                bleft--;
                if (bleft <= 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        int n0;
        int guard;
        logic [15:0] ra, rb;
        logic [31:0] e;

        vt[0] = '{16'd1000, 16'd7, 16, 50, 16'd142, 16'd6, 1'b0};
        vt[1] = '{16'h1234, 16'h0000, 16, 0, 16'hFFFF, 16'h1234, 1'b1};
        vt[2] = '{16'd100, 16'd10, 3, 0, 16'd10, 16'd0, 1'b0};
        vt[3] = '{16'hFFFF, 16'd1, 1, 50, 16'hFFFF, 16'd0, 1'b0};
        vt[4] = '{16'd5, 16'd9, 2, 0, 16'd0, 16'd5, 1'b0};
        vt[5] = '{16'd0, 16'd0, 5, 3, 16'hFFFF, 16'd0, 1'b1};

        rst = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        tick(3);
        check("rst div_start", div_start, 0);
        check("rst div_a", div_a, 0);
        check("rst div_b", div_b, 0);
        check("rst tx_start", tx_start, 0);
        check("rst tx_data", tx_data, 0);
        check("rst y_to_led", y_to_led, 0);
        check("rst dz_err", dz_err, 0);
        check("rst ovr_err", ovr_err, 0);
        check("rst busy", busy, 0);
        rst = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            div_lat = vt[i].lat;
            tx_hold = vt[i].hold;
            n0 = n_start;
            send_frame(vt[i].a, vt[i].b, 1'b0);
            finish_frame($sformatf("vec%0d", i), vt[i].a, vt[i].b,
                         vt[i].q, vt[i].r, vt[i].dz, n0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            e = ref_div(ra, rb);
            div_lat = $urandom_range(1, 20);
            case ($urandom_range(0, 2))
                0: tx_hold = 0;
                1: tx_hold = 2;
                default: tx_hold = 50;
            endcase
            n0 = n_start;
            send_frame(ra, rb, 1'b0);
            finish_frame($sformatf("rnd%0d", i), ra, rb, e[15:0], e[31:16],
                         rb == 16'd0, n0);
        end

        tx_hold = 0;
        div_lat = 6;
        send_byte(8'h55);
        tick(1);
        send_byte(8'h66);
        tick(TB_TO);
        check("timeout busy", busy, 0);
        n0 = n_start;
        send_frame(16'd10, 16'd3, 1'b0);
        finish_frame("timeout_frame", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, n0);

        n0 = n_start;
        send_byte(8'hAA);
        tick(TB_TO - 1);
        send_frame(16'd100, 16'd10, 1'b0);
        finish_frame("timeout_same_cycle", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, n0);

        tx_hold = 50;
        div_lat = 40;
        n0 = n_start;
        send_frame(16'd2000, 16'd9, 1'b0);
        tick(10);
        send_byte(8'h99);
        check("ovr in div_wait", ovr_err, 1);
        guard = 0;
        while (txq.size() < 1 && guard < 200) begin
            tick(1);
            guard++;
        end
        tick(5);
        check("busy in drain", busy, 1);
        send_byte(8'h77);
        check("ovr in drain", ovr_err, 1);
        finish_frame("ovr_frame", 16'd2000, 16'd9, 16'd222, 16'd2, 1'b0, n0);
        check("ovr sticky", ovr_err, 1);
        tx_hold = 0;
        div_lat = 4;
        n0 = n_start;
        send_byte(8'h01);
        check("ovr cleared", ovr_err, 0);
        send_frame(16'd1, 16'd5, 1'b1);
        finish_frame("after_ovr", 16'd1, 16'd5, 16'd0, 16'd1, 1'b0, n0);

        div_lat = 30;
        stab_chk = 1'b0;
        send_frame(16'd80, 16'd5, 1'b0);
        tick(8);
        check("pre_rst busy", busy, 1);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst div_start", div_start, 0);
        check("midrst div_a", div_a, 0);
        check("midrst div_b", div_b, 0);
        check("midrst y_to_led", y_to_led, 0);
        check("midrst dz_err", dz_err, 0);
        check("midrst ovr_err", ovr_err, 0);
        check("midrst busy", busy, 0);
        tick(40);
        check("stray done tx_count", txq.size(), 0);
        check("stray done busy", busy, 0);
        check("stray done y_to_led", y_to_led, 0);
        stab_chk = 1'b1;
        div_lat = 16;
        n0 = n_start;
        send_frame(16'd100, 16'd10, 1'b0);
        finish_frame("post_rst", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, n0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_div_sched.md
Name: uart_div_sched

Overview:
Sequencer between the UART byte interfaces and a shared 16-bit divider datapath.
- Assembles a 4-byte operand frame from the UART receiver.
- Launches the divider with a start/done handshake, handling divide-by-zero locally.
- Streams the 4-byte result frame to the UART transmitter under a busy handshake.
- Owns frame timing: inter-byte timeout and rejection of bytes arriving while a frame is in service.

Parameters:
BIT_MAX, 16, operand/result width (fixed at 16; frame is 2 bytes per operand)
TIMEOUT_CYC, 434000, max clk cycles between received bytes of one frame before the partial frame is discarded
DZ_QUOT, 16'hFFFF, quotient reported on divide-by-zero

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
div_start  out  1  one-cycle pulse launching the divider
div_a  out  16  dividend, stable from div_start until div_done
div_b  out  16  divisor, stable from div_start until div_done
div_done  in  1  one-cycle pulse: div_q/div_r valid this cycle
div_q  in  16  quotient
div_r  in  16  remainder
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  byte to transmit, held until tx_busy falls
tx_busy  in  1  transmitter busy
y_to_led  out  24  {8'h00, last quotient}
dz_err  out  1  sticky: last frame was divide-by-zero
ovr_err  out  1  sticky: a byte arrived outside COLLECT
busy  out  1  high in every state except COLLECT

Behaviour:
Reset values (rst low at posedge clk):
- All outputs 0; state COLLECT; byte count 0; timeout counter 0.
- Operand/result registers 0.
- Reset mid-operation abandons the frame. A later stray div_done or tx_busy edge has no effect while in COLLECT.

Frame formats (little-endian):
- Inbound byte order: a[7:0], a[15:8], b[7:0], b[15:8].
- Outbound byte order: q[7:0], q[15:8], r[7:0], r[15:8].

States:
- COLLECT
  - On rx_valid: store the byte at position cnt, increment cnt, clear the timeout counter.
  - On the 4th byte: go to CHECK next cycle. The stored operands are visible on div_a/div_b from that cycle.
  - While cnt != 0 and no rx_valid: the timeout counter increments. When it reaches TIMEOUT_CYC-1: cnt <= 0, counter <= 0, bytes discarded, no error flag.
  - The first byte of a new frame clears dz_err and ovr_err.
- CHECK
  - b == 0: q <= DZ_QUOT, r <= a, dz_err <= 1, go to TX_LOAD. No div_start is issued.
  - Otherwise: div_start = 1 for this one cycle, go to DIV_WAIT.
- DIV_WAIT
  - Wait for div_done; capture div_q/div_r the same cycle.
  - y_to_led <= {8'h00, div_q}; go to TX_LOAD.
  - No timeout: the divider is trusted.
- TX_LOAD
  - When tx_busy == 0: present byte index k on tx_data, pulse tx_start one cycle, go to TX_ACK.
- TX_ACK
  - Wait for tx_busy == 1, then go to TX_DRAIN.
  - If tx_busy is still 0 after 4 cycles, treat the byte as accepted and go to TX_DRAIN.
- TX_DRAIN
  - Wait for tx_busy == 0.
  - k == 3: cnt <= 0, go to COLLECT.
  - Otherwise k <= k+1, go to TX_LOAD.

Boundary and timing rules:
- In the divide-by-zero path, y_to_led also updates with DZ_QUOT.
- rx_valid in any state other than COLLECT: byte dropped, ovr_err <= 1.
- rx_valid on the same cycle the timeout fires: the timeout wins and the byte is stored as byte 0 of a new frame (cnt <= 1).
- Latency (nonzero b): div_start is asserted 2 cycles after the 4th rx_valid. The first tx_start is 1 cycle after div_done, provided tx_busy is low.

Decomposition:
Shared package uart_div_pkg holds:
- state encoding (COLLECT, CHECK, DIV_WAIT, TX_LOAD, TX_ACK, TX_DRAIN);
- FRAME_BYTES = 4;
- ACK_WAIT_CYC = 4;
- byte-position constants.

One sub-module, byte_tx_seq, owns the TX_LOAD/TX_ACK/TX_DRAIN loop:
- inputs: a 32-bit result word and a go pulse;
- output: a done pulse;
- drives tx_start/tx_data.

The top holds the collect/check/divide FSM, the timeout counter and the flags.

Test Plan:
- Send 0xE8,0x03,0x07,0x00 (1000/7), divider model returns after 16 cycles with q=142, r=6.
  - Expect one div_start with div_a=0x03E8, div_b=0x0007.
  - Expect tx bytes 0x8E,0x00,0x06,0x00.
  - Expect y_to_led=0x00008E and busy low afterwards.
- Send 0x34,0x12,0x00,0x00.
  - Expect no div_start and dz_err=1.
  - Expect tx bytes 0xFF,0xFF,0x34,0x12 and y_to_led=0x00FFFF.
- Send 2 bytes, idle TIMEOUT_CYC cycles, then send 0x0A,0x00,0x03,0x00.
  - Expect the operands to be 10/3, giving tx bytes 0x03,0x00,0x01,0x00.
- Inject rx_valid during DIV_WAIT and during TX_DRAIN.
  - Expect ovr_err=1 and the result frame unchanged.
  - ovr_err clears on the first byte of the next frame.
- Assert rst low during DIV_WAIT, then pulse div_done.
  - Expect all outputs 0 and no tx_start.
  - A following 100/10 frame must yield 0x0A,0x00,0x00,0x00.
- Transmitter model holding tx_busy high 50 cycles per byte, and a second model that never raises busy.
  - Expect exactly 4 tx_start pulses per frame in both cases, each only when tx_busy==0.
